// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher_feeder slice.
// The CIPHER_FEEDER_PAD_EN macro enables message padding in cipher_feeder.
package cipher_pkg;

    localparam int CH_W = 8;
    localparam logic [CH_W-1:0] SEED_FALLBACK = 8'h01;
    localparam int PAD_ALIGN = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEY    = 3'd1,
        LOAD   = 3'd2,
        ARM    = 3'd3,
        STREAM = 3'd4,
        DONE   = 3'd5
    } feeder_state_t;

    // An all-zero seed would stall the keystream, so it is replaced by the fallback.
    function automatic logic [CH_W-1:0] fold_seed(input logic [CH_W-1:0] acc);
        if (acc == {CH_W{1'b0}}) begin
            return SEED_FALLBACK;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/cipher_msg_buf.sv
// DEPTH x W message store: synchronous write port, registered read port.
// The read register holds its value whenever rd_en is low.
module cipher_msg_buf
    import cipher_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = CH_W
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rd_data_r;

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset and held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cipher_feeder.sv
// cipher_feeder: folds a key phrase into an 8-bit seed, buffers one message,
// then drives cipher_core with seed, a start pulse and a gapless byte stream.
// Optional padding to a multiple of four bytes: define CIPHER_FEEDER_PAD_EN.
module cipher_feeder
    import cipher_pkg::*;
#(
    parameter int DEPTH = 16
`ifdef CIPHER_FEEDER_PAD_EN
    ,
    parameter logic [CH_W-1:0] PAD_CHAR = 8'h20
`endif
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [CH_W-1:0] key_data,
    input  logic            key_last,
    output logic            key_ready,
    input  logic            in_valid,
    input  logic [CH_W-1:0] in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic [CH_W-1:0] seed_out,
    output logic            start_out,
    output logic [CH_W-1:0] ch_out,
    output logic            ch_valid,
    output logic            busy,
    output logic            done,
`ifdef CIPHER_FEEDER_PAD_EN
    output logic [1:0]      pad_count,
`endif
    output logic            overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    feeder_state_t   state_r, state_s;
    logic [CH_W-1:0] acc_r;
    logic [CH_W-1:0] seed_r;
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   rd_r;
    logic            overflow_r;
    logic            key_ready_r, in_ready_r, start_r, ch_valid_r, busy_r, done_r;

    logic            key_acc_s, in_acc_s, len_full_s;
    logic            wr_en_s, rd_en_s;
    logic [LW-1:0]   len_inc_s, len_exit_s;
    logic [CH_W-1:0] buf_rdata_s;

`ifdef CIPHER_FEEDER_PAD_EN
    logic [LW-1:0]   len_round_s;
    logic [LW-1:0]   data_len_r;
    logic [1:0]      pad_count_r;
    logic            pad_sel_r;
`endif

    assign key_acc_s  = key_valid && key_ready_r;
    assign in_acc_s   = in_valid && in_ready_r;
    assign len_full_s = (len_r == LW'(DEPTH));
    assign len_inc_s  = len_r + LW'(wr_en_s);

    // Next-state decode plus buffer write/read strobes.
    always_comb begin
        state_s = state_r;
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_acc_s) begin
                    if (key_last) begin
                        state_s = LOAD;
                    end else begin
                        state_s = KEY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            KEY: begin
                if (key_acc_s && key_last) begin
                    state_s = LOAD;
                end else begin
                    state_s = KEY;
                end
            end
            LOAD: begin
                if (in_acc_s) begin
                    wr_en_s = !len_full_s;
                    if (in_last) begin
                        state_s = ARM;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            ARM: begin
                // Prefetch byte 0 so it is on ch_out in the first STREAM cycle.
                rd_en_s = 1'b1;
                state_s = STREAM;
            end
            STREAM: begin
                // rd_r is the next fetch address; reaching len_r means the last byte is out.
                if (rd_r == len_r) begin
                    state_s = DONE;
                end else begin
                    rd_en_s = 1'b1;
                    state_s = STREAM;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Length that the stream will use once the message is complete.
    always_comb begin
`ifdef CIPHER_FEEDER_PAD_EN
        len_round_s = (len_inc_s + LW'(PAD_ALIGN - 1)) & ~LW'(PAD_ALIGN - 1);
        if (len_round_s > LW'(DEPTH)) begin
            len_exit_s = LW'(DEPTH);
        end else begin
            len_exit_s = len_round_s;
        end
`else
        len_exit_s = len_inc_s;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Key accumulator, seed capture and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= {CH_W{1'b0}};
            seed_r     <= {CH_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (key_acc_s) begin
            // XOR with 0x00 is the identity, so zero bytes drop out naturally.
            overflow_r <= 1'b0;
            if (key_last) begin
                seed_r <= fold_seed(acc_r ^ key_data);
                acc_r  <= {CH_W{1'b0}};
            end else begin
                acc_r  <= acc_r ^ key_data;
            end
        end else if (wr_en_s && (len_inc_s == LW'(DEPTH)) && !in_last) begin
            overflow_r <= 1'b1;
        end
    end

    // Message length and stream read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r <= {LW{1'b0}};
            rd_r  <= {LW{1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_acc_s && in_last) begin
                        len_r <= len_exit_s;
                    end else begin
                        len_r <= len_inc_s;
                    end
                end
                ARM, STREAM: begin
                    if (rd_en_s) begin
                        rd_r <= rd_r + {{(LW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    len_r <= {LW{1'b0}};
                    rd_r  <= {LW{1'b0}};
                end
                default: begin
                    len_r <= len_r;
                    rd_r  <= rd_r;
                end
            endcase
        end
    end

`ifdef CIPHER_FEEDER_PAD_EN
    // Real data length and pad count captured as the message closes; pad select tracks each fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_len_r  <= {LW{1'b0}};
            pad_count_r <= 2'd0;
            pad_sel_r   <= 1'b0;
        end else begin
            if ((state_r == LOAD) && in_acc_s && in_last) begin
                data_len_r  <= len_inc_s;
                pad_count_r <= 2'(len_exit_s - len_inc_s);
            end
            if (rd_en_s) begin
                pad_sel_r <= (rd_r >= data_len_r);
            end
        end
    end

    assign pad_count = pad_count_r;
    assign ch_out    = pad_sel_r ? PAD_CHAR : buf_rdata_s;
`else
    assign ch_out    = buf_rdata_s;
`endif

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_ready_r <= 1'b1;
            in_ready_r  <= 1'b0;
            start_r     <= 1'b0;
            ch_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            key_ready_r <= (state_s == IDLE) || (state_s == KEY);
            in_ready_r  <= (state_s == LOAD);
            start_r     <= (state_s == ARM);
            ch_valid_r  <= (state_s == STREAM);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    cipher_msg_buf #(
        .DEPTH (DEPTH),
        .W     (CH_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_addr (len_r[AW-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_r[AW-1:0]),
        .rd_data (buf_rdata_s)
    );

    assign key_ready = key_ready_r;
    assign in_ready  = in_ready_r;
    assign seed_out  = seed_r;
    assign start_out = start_r;
    assign ch_valid  = ch_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_cipher_feeder.sv
// Directed bench for cipher_feeder with a byte scoreboard on the stream output.
module tb_cipher_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid, key_last, key_ready;
    logic [7:0] key_data;
    logic       in_valid, in_last, in_ready;
    logic [7:0] in_data;
    logic [7:0] seed_out, ch_out;
    logic       start_out, ch_valid, busy, done, overflow;
`ifdef CIPHER_FEEDER_PAD_EN
    logic [1:0] pad_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] key_q[$];
    logic [7:0] msg_q[$];

    always #5 clk = ~clk;

    cipher_feeder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_last  (key_last),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .seed_out  (seed_out),
        .start_out (start_out),
        .ch_out    (ch_out),
        .ch_valid  (ch_valid),
        .busy      (busy),
        .done      (done),
`ifdef CIPHER_FEEDER_PAD_EN
        .pad_count (pad_count),
`endif
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every presented byte must match the oldest expected one.
    always @(negedge clk) begin
        if (ch_valid) begin
            logic have;
            have = (exp_q.size() > 0);
            chk("byte_expected", {31'd0, have}, 32'd1);
            if (have) begin
                chk("ch_out", {24'd0, ch_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_key(input string s);
        key_q.delete();
        for (int i = 0; i < s.len(); i++) key_q.push_back(s[i]);
    endtask

    task automatic set_msg(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic send_key();
        for (int i = 0; i < key_q.size(); i++) begin
            key_valid = 1'b1;
            key_data  = key_q[i];
            key_last  = (i == key_q.size() - 1);
            chk("key_ready", {31'd0, key_ready}, 32'd1);
            @(posedge clk); #1;
            key_valid = 1'b0;
            key_last  = 1'b0;
        end
    endtask

    // Drives the message; gap inserts an idle cycle between bytes, poke offers a key byte then.
    task automatic send_msg(input bit gap, input bit poke);
        for (int i = 0; i < msg_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = msg_q[i];
            in_last  = (i == msg_q.size() - 1);
            chk("in_ready", {31'd0, in_ready}, 32'd1);
            if (i < DEPTH) exp_q.push_back(msg_q[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (gap && (i != msg_q.size() - 1)) begin
                key_valid = poke;
                key_data  = 8'h5A;
                key_last  = 1'b1;
                chk("key_ready_in_load", {31'd0, key_ready}, 32'd0);
                @(posedge clk); #1;
                key_valid = 1'b0;
                key_last  = 1'b0;
            end
        end
    endtask

    // Called one cycle after in_last is accepted: checks ARM, n stream cycles, DONE, IDLE.
    task automatic after_load(input logic [7:0] seed, input int n, input bit ovf);
        chk("start_out", {31'd0, start_out}, 32'd1);
        chk("arm_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("arm_seed", {24'd0, seed_out}, {24'd0, seed});
        chk("arm_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("stream_ch_valid", {31'd0, ch_valid}, 32'd1);
            chk("stream_start", {31'd0, start_out}, 32'd0);
            chk("stream_seed", {24'd0, seed_out}, {24'd0, seed});
        end
        @(posedge clk); #1;
        chk("done", {31'd0, done}, 32'd1);
        chk("done_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("done_seed", {24'd0, seed_out}, {24'd0, seed});
        chk("overflow", {31'd0, overflow}, {31'd0, ovf});
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_key_ready", {31'd0, key_ready}, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0; key_data = 8'h00; key_last = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", {31'd0, key_ready}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_start", {31'd0, start_out}, 32'd0);
        chk("rst_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_seed", {24'd0, seed_out}, 32'd0);
        chk("rst_ch_out", {24'd0, ch_out}, 32'd0);
        rst = 1'b0;

        // Basic key and message.
        set_key("Tintareanu"); send_key();
        set_msg("Paula"); send_msg(1'b0, 1'b0);
        after_load(8'h2B, 5, 1'b0);

        // Zero XOR and a lone 0x00 key byte both fall back to 0x01; one-byte messages.
        set_key("AA"); send_key();
        set_msg("x"); send_msg(1'b0, 1'b0);
        after_load(8'h01, 1, 1'b0);
        key_q.delete(); key_q.push_back(8'h00); send_key();
        set_msg("y"); send_msg(1'b0, 1'b0);
        after_load(8'h01, 1, 1'b0);

        // Exactly DEPTH bytes: no overflow. Then 20 bytes: truncated to DEPTH, overflow held.
        set_key("k"); send_key();
        set_msg("0123456789abcdef"); send_msg(1'b0, 1'b0);
        after_load(8'h6B, 16, 1'b0);
        set_key("k"); send_key();
        set_msg("0123456789ABCDEFGHIJ"); send_msg(1'b0, 1'b0);
        after_load(8'h6B, 16, 1'b1);
        @(posedge clk); #1;
        chk("overflow_held", {31'd0, overflow}, 32'd1);

        // Gapped message with key bytes offered during LOAD.
        set_key("K9"); send_key();
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);
        set_msg("gapless"); send_msg(1'b1, 1'b1);
        after_load(8'h72, 7, 1'b0);

        // Reset in the third stream cycle, then a fresh transaction.
        set_key("rx"); send_key();
        set_msg("abcdef"); send_msg(1'b0, 1'b0);
        chk("mid_start", {31'd0, start_out}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_ch_valid", {31'd0, ch_valid}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_key_ready", {31'd0, key_ready}, 32'd1);
        chk("mid_rst_ch_out", {24'd0, ch_out}, 32'd0);
        chk("mid_rst_seed", {24'd0, seed_out}, 32'd0);
        set_key("new"); send_key();
        set_msg("abc"); send_msg(1'b0, 1'b0);
        after_load(8'h7C, 3, 1'b0);

`ifdef CIPHER_FEEDER_PAD_EN
        // Padding to a multiple of four.
        set_key("p"); send_key();
        set_msg("abcde"); send_msg(1'b0, 1'b0);
        repeat (3) exp_q.push_back(8'h20);
        chk("pad_count", {30'd0, pad_count}, 32'd3);
        after_load(8'h70, 8, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
